// File: rtl/depkt_pkg.sv
// Shared constants, channel-type encoding and FSM state types for the depacketizing router.
package depkt_pkg;

  localparam int unsigned PKT_W_DEF     = 35;
  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned TYPE_W_DEF    = 2;
  localparam int unsigned NUM_CH_DEF    = 4;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam int unsigned PAYLOAD_W_DEF = PKT_W_DEF - ADDR_W_DEF - TYPE_W_DEF;
  localparam int unsigned DROP_W        = 16;

  typedef enum logic [1:0] {
    CH_WEIGHT = 2'd0,
    CH_IFMAP  = 2'd1,
    CH_SPIKE  = 2'd2,
    CH_PSUM   = 2'd3
  } ch_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_RET  = 2'd2
  } out_state_e;

  // Saturating increment so the drop counter sticks at all-ones.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/depkt_out_port.sv
// One output channel: payload FIFO, acknowledge synchronizer and 4-phase sender FSM.
module depkt_out_port
  import depkt_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_c,
  input  logic [PAYLOAD_W-1:0] push_data,
  output logic                 can_push_c,
  input  logic                 out_ack,
  output logic                 out_req,
  output logic [PAYLOAD_W-1:0] out_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 ack_meta;
  logic                 ack_sync;
  out_state_e           state;
  logic                 staged;

  logic empty_c;
  logic full_c;
  logic pop_c;
  logic do_push_c;

  // A pop in this cycle frees the slot, so a full FIFO can still take a push.
  assign empty_c    = (count == '0);
  assign full_c     = (count == CNT_W'(DEPTH));
  assign pop_c      = (state == O_REQ) && ack_sync;
  assign can_push_c = !full_c || pop_c;
  assign do_push_c  = push_c && can_push_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= out_ack;
      ack_sync <= ack_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= push_data;
  end

  // Head is copied to out_data one cycle before out_req so data is set up first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= O_IDLE;
      staged   <= 1'b0;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        O_IDLE: begin
          if (staged) begin
            out_req <= 1'b1;
            staged  <= 1'b0;
            state   <= O_REQ;
          end else if (!empty_c) begin
            out_data <= mem[rd_ptr];
            staged   <= 1'b1;
          end
        end
        O_REQ: begin
          if (ack_sync) begin
            out_req <= 1'b0;
            state   <= O_RET;
          end
        end
        O_RET: begin
          if (!ack_sync) state <= O_IDLE;
        end
        default: state <= O_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/depacket_router.sv
// Accepts 4-phase bundled-data packets, drops foreign or unknown-type ones, and
// queues payloads into per-type output channels with their own 4-phase senders.
module depacket_router
  import depkt_pkg::*;
#(
  parameter int unsigned PKT_W      = PKT_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned TYPE_W     = TYPE_W_DEF,
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned LOCAL_ADDR = 0
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        in_req,
  output logic                                        in_ack,
  input  logic [PKT_W-1:0]                            in_data,
  output logic [NUM_CH-1:0]                           out_req,
  input  logic [NUM_CH-1:0]                           out_ack,
  output logic [NUM_CH*(PKT_W-ADDR_W-TYPE_W)-1:0]     out_data,
  output logic [DROP_W-1:0]                           drop_cnt
);

  localparam int unsigned PAYLOAD_W = PKT_W - ADDR_W - TYPE_W;

  logic       req_meta;
  logic       req_sync;
  in_state_e  state;

  logic [ADDR_W-1:0]    dest_f;
  logic [TYPE_W-1:0]    type_f;
  logic [PAYLOAD_W-1:0] payload_f;

  logic [NUM_CH-1:0] sel_c;
  logic [NUM_CH-1:0] push_c;
  logic [NUM_CH-1:0] can_push_c;
  logic              drop_c;
  logic              accept_c;

  assign dest_f    = in_data[PKT_W-1 -: ADDR_W];
  assign type_f    = in_data[PKT_W-ADDR_W-1 -: TYPE_W];
  assign payload_f = in_data[PAYLOAD_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= in_req;
      req_sync <= req_meta;
    end
  end

  // A type with no matching channel leaves sel_c empty and is dropped.
  always_comb begin
    sel_c = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      sel_c[ch] = (32'(type_f) == ch);
    end
  end

  assign drop_c   = (dest_f != ADDR_W'(LOCAL_ADDR)) || (sel_c == '0);
  assign accept_c = (state == IDLE) && req_sync && (drop_c || ((sel_c & can_push_c) != '0));
  assign push_c   = sel_c & {NUM_CH{accept_c && !drop_c}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      in_ack   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            in_ack <= 1'b1;
            state  <= ACKED;
            if (drop_c) drop_cnt <= sat_inc(drop_cnt);
          end
        end
        ACKED: begin
          if (!req_sync) begin
            in_ack <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_port
    depkt_out_port #(
      .PAYLOAD_W (PAYLOAD_W),
      .DEPTH     (DEPTH)
    ) u_port (
      .clk        (clk),
      .rst_n      (reset_n),
      .push_c     (push_c[g]),
      .push_data  (payload_f),
      .can_push_c (can_push_c[g]),
      .out_ack    (out_ack[g]),
      .out_req    (out_req[g]),
      .out_data   (out_data[g*PAYLOAD_W +: PAYLOAD_W])
    );
  end

endmodule
